// File: rtl/tenkey_debounce.sv
// Input conditioning for the lock controller: synchronises and debounces the tenkey
// switches and the close button, and rejects multi-key presses.
module tenkey_debounce #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [9:0] raw_key,
    input  logic       raw_close,
    output logic [9:0] tenkey,
    output logic       close,
    output logic       key_err
);

    typedef enum logic [1:0] {
        IDLE,
        DETECT,
        PRESSED,
        BLOCK
    } key_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [9:0]       s1_key;
    logic [9:0]       sk;
    logic             s1_close;
    logic             sc;
    key_state_t       state;
    logic [9:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cc;
    logic             cl;
    logic             sk_multi;
    logic             sk_onehot;

    // Clearing the lowest set bit leaves something behind only when two or more bits are set.
    assign sk_multi  = (sk & (sk - 10'd1)) != 10'd0;
    assign sk_onehot = (sk != 10'd0) && !sk_multi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            s1_key   <= '0;
            sk       <= '0;
            s1_close <= 1'b0;
            sc       <= 1'b0;
        end else begin
            // NOTE: non-blocking so the second stage captures the first stage's previous value,
            // giving a true two-flop synchroniser instead of a single flop.
            s1_key   <= raw_key;
            sk       <= s1_key;
            s1_close <= raw_close;
            sc       <= s1_close;
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cand    <= '0;
            cnt     <= '0;
            tenkey  <= '0;
            key_err <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sk_onehot) begin
                        cand  <= sk;
                        cnt   <= CNT_ONE;
                        state <= DETECT;
                    end else if (sk_multi) begin
                        key_err <= 1'b1;
                        cnt     <= '0;
                        state   <= BLOCK;
                    end
                end
                DETECT: begin
                    if (sk == cand) begin
                        if (cnt == CNT_LAST) begin
                            tenkey <= cand;
                            cnt    <= '0;
                            state  <= PRESSED;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else if (sk_multi) begin
                        key_err <= 1'b1;
                        cnt     <= '0;
                        state   <= BLOCK;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                // Held key is frozen; only an all-released run of DEBOUNCE samples ends it.
                PRESSED: begin
                    if (sk == 10'd0) begin
                        if (cnt == CNT_LAST) begin
                            tenkey <= '0;
                            cnt    <= '0;
                            state  <= IDLE;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                BLOCK: begin
                    if (sk == 10'd0) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Close path: level follows sc after DEBOUNCE differing samples; pulse on the rise only.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            cc    <= '0;
            cl    <= 1'b0;
            close <= 1'b0;
        end else begin
            close <= 1'b0;
            if (sc != cl) begin
                if (cc == CNT_LAST) begin
                    cl    <= sc;
                    cc    <= '0;
                    close <= sc;
                end else begin
                    cc <= sat_inc(cc);
                end
            end else begin
                cc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tenkey_debounce.sv
// Self-checking bench for tenkey_debounce: directed scenarios plus random bouncing
// stimulus, compared every cycle against a run-length reference model.
module tb_tenkey_debounce;

    localparam int DEBOUNCE = 4;

    logic       ck;
    logic       reset;
    logic [9:0] raw_key;
    logic       raw_close;
    logic [9:0] tenkey;
    logic       close;
    logic       key_err;

    tenkey_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(8)) dut (
        .ck       (ck),
        .reset    (reset),
        .raw_key  (raw_key),
        .raw_close(raw_close),
        .tenkey   (tenkey),
        .close    (close),
        .key_err  (key_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int vectors     = 0;
    int miscompares = 0;
    int rise_cnt    = 0;
    int close_cnt   = 0;
    int err_cnt     = 0;
    logic prev_any  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the synchroniser is a two-deep queue; key decisions are run lengths
    // of identical samples, three modes (free / holding a key / locked out after multi-press).
    typedef enum {M_FREE, M_HELD, M_LOCKED} mode_t;

    logic [9:0] kq[$];
    logic       cq[$];
    mode_t      m_mode;
    logic [9:0] m_run_key;
    int         m_run_len;
    int         m_zero_run;
    int         m_close_run;
    logic       m_level;
    logic [9:0] exp_tenkey;
    logic       exp_close;
    logic       exp_err;

    task automatic model_clear();
        kq.delete();
        cq.delete();
        repeat (2) begin
            kq.push_back(10'd0);
            cq.push_back(1'b0);
        end
        m_mode      = M_FREE;
        m_run_key   = '0;
        m_run_len   = 0;
        m_zero_run  = 0;
        m_close_run = 0;
        m_level     = 1'b0;
        exp_tenkey  = '0;
        exp_close   = 1'b0;
        exp_err     = 1'b0;
    endtask

    task automatic model_edge();
        logic [9:0] s;
        logic       c;
        int         ones;
        s = kq.pop_front();
        kq.push_back(raw_key);
        c = cq.pop_front();
        cq.push_back(raw_close);
        ones      = $countones(s);
        exp_err   = 1'b0;
        exp_close = 1'b0;
        case (m_mode)
            M_FREE: begin
                if (ones >= 2) begin
                    exp_err    = 1'b1;
                    m_mode     = M_LOCKED;
                    m_zero_run = 0;
                    m_run_len  = 0;
                end else if (m_run_len == 0) begin
                    if (ones == 1) begin
                        m_run_key = s;
                        m_run_len = 1;
                    end
                end else if (s == m_run_key) begin
                    m_run_len++;
                    if (m_run_len == DEBOUNCE) begin
                        exp_tenkey = s;
                        m_mode     = M_HELD;
                        m_zero_run = 0;
                        m_run_len  = 0;
                    end
                end else begin
                    m_run_len = 0;
                end
            end
            default: begin
                if (s == 10'd0) begin
                    m_zero_run++;
                    if (m_zero_run == DEBOUNCE) begin
                        exp_tenkey = '0;
                        m_mode     = M_FREE;
                    end
                end else begin
                    m_zero_run = 0;
                end
            end
        endcase
        if (c != m_level) begin
            m_close_run++;
            if (m_close_run == DEBOUNCE) begin
                m_level     = c;
                m_close_run = 0;
                exp_close   = c;
            end
        end else begin
            m_close_run = 0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge ck or negedge reset);
            if (!reset) model_clear();
            else model_edge();
        end
    end

    // Advance n cycles, comparing all outputs at each falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge ck);
            check("tenkey", 32'(tenkey), 32'(exp_tenkey));
            check("close", 32'(close), 32'(exp_close));
            check("key_err", 32'(key_err), 32'(exp_err));
            if ((|tenkey) && !prev_any) rise_cnt++;
            prev_any = |tenkey;
            if (close) close_cnt++;
            if (key_err) err_cnt++;
        end
    endtask

    task automatic random_phase(input int segs);
        logic [9:0] pat;
        int         b1;
        int         b2;
        int         len;
        for (int i = 0; i < segs; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pat = 10'd1 << $urandom_range(0, 9);
                4, 5:       pat = 10'd0;
                6: begin
                    b1  = $urandom_range(0, 9);
                    b2  = (b1 + 1 + $urandom_range(0, 8)) % 10;
                    pat = (10'd1 << b1) | (10'd1 << b2);
                end
                7:       pat = 10'($urandom);
                default: pat = raw_key;
            endcase
            raw_key = pat;
            if ($urandom_range(0, 2) == 0) raw_close = ~raw_close;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 4);
            step(len);
        end
    endtask

    initial begin
        int r0;
        int e0;
        int c0;
        reset     = 1'b0;
        raw_key   = '0;
        raw_close = 1'b0;
        step(3);
        check("rst_tenkey", 32'(tenkey), 32'h0);
        check("rst_close", 32'(close), 32'h0);
        check("rst_key_err", 32'(key_err), 32'h0);
        reset = 1'b1;
        step(3);

        // Clean press and release of digit 3.
        e0 = err_cnt;
        raw_key = 10'h008;
        step(5);
        check("t1_before", 32'(tenkey), 32'h0);
        step(1);
        check("t1_on", 32'(tenkey), 32'h008);
        step(14);
        raw_key = 10'h000;
        step(5);
        check("t1_held", 32'(tenkey), 32'h008);
        step(1);
        check("t1_off", 32'(tenkey), 32'h0);
        check("t1_no_err", 32'(err_cnt - e0), 32'h0);
        step(4);

        // Bouncing contact settles on digit 1.
        r0 = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            raw_key = (i % 2 == 0) ? 10'h002 : 10'h000;
            step(1);
        end
        raw_key = 10'h002;
        step(5);
        check("t2_before", 32'(tenkey), 32'h0);
        step(1);
        check("t2_on", 32'(tenkey), 32'h002);
        step(4);
        check("t2_rises", 32'(rise_cnt - r0), 32'h1);
        raw_key = 10'h000;
        step(10);

        // Multi-key press is rejected, then a single key is accepted.
        e0 = err_cnt;
        raw_key = 10'h011;
        step(10);
        raw_key = 10'h000;
        step(10);
        raw_key = 10'h001;
        step(5);
        check("t3_before", 32'(tenkey), 32'h0);
        step(1);
        check("t3_on", 32'(tenkey), 32'h001);
        check("t3_err_once", 32'(err_cnt - e0), 32'h1);
        raw_key = 10'h000;
        step(10);

        // Extra key while pressed neither changes the digit nor flags an error.
        e0 = err_cnt;
        raw_key = 10'h004;
        step(6);
        check("t4_on", 32'(tenkey), 32'h004);
        raw_key = 10'h084;
        step(5);
        check("t4_extra", 32'(tenkey), 32'h004);
        raw_key = 10'h000;
        step(5);
        check("t4_held", 32'(tenkey), 32'h004);
        step(1);
        check("t4_off", 32'(tenkey), 32'h0);
        check("t4_no_err", 32'(err_cnt - e0), 32'h0);
        step(4);

        // Close glitch is ignored; a steady press gives exactly one pulse.
        c0 = close_cnt;
        raw_close = 1'b1;
        step(2);
        raw_close = 1'b0;
        step(6);
        check("t5_glitch", 32'(close_cnt - c0), 32'h0);
        raw_close = 1'b1;
        step(5);
        check("t5_before", 32'(close), 32'h0);
        step(1);
        check("t5_pulse", 32'(close), 32'h1);
        step(1);
        check("t5_after", 32'(close), 32'h0);
        step(23);
        check("t5_once", 32'(close_cnt - c0), 32'h1);
        raw_close = 1'b0;
        step(8);

        // Asynchronous reset while a key is held, then re-acceptance.
        raw_key = 10'h200;
        step(8);
        check("t6_on", 32'(tenkey), 32'h200);
        #2 reset = 1'b0;
        #1 check("t6_async_clear", 32'(tenkey), 32'h0);
        step(2);
        reset = 1'b1;
        step(5);
        check("t6_before", 32'(tenkey), 32'h0);
        step(1);
        check("t6_reon", 32'(tenkey), 32'h200);
        raw_key = 10'h000;
        step(10);

        random_phase(300);
        raw_key   = '0;
        raw_close = 1'b0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
